sobel_uart_tx_streamer: RTL and testbench

SOBEL_UART_TX_STREAMER -- requirements
Module: sobel_uart_tx_stream

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_uart_baud_gen.sv | 28 ++
 rtl/sobel_uart_tx_streamer.sv | 158 +++++++++++++++
 tb/tb_sobel_uart_tx_streamer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared state encoding and serial frame constants for the Sobel UART streamer.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_SETTLE,
    ST_DONE
  } tx_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        LINE_IDLE   = 1'b1;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sobel_uart_baud_gen.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles while run_i is high and
// is held at zero otherwise, so each frame starts on a fresh bit boundary.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sobel_uart_tx_streamer.sv
// Streams a HEIGHT x WIDTH processed image out of the Sobel output buffer as
// 8N1 UART frames (8E1 when SOBEL_TX_PARITY_EN is defined).
module sobel_uart_tx_streamer
  import sobel_pkg::*;
#(
  parameter int unsigned HEIGHT       = 4,
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic [7:0] tx_dados,
  output logic       tx_pronto,
  output logic       serial_tx,
  output logic       ocupado,
  output logic       fim_transmissao
);

  localparam int unsigned TOTAL = HEIGHT * WIDTH;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [CNT_W-1:0]     count_q;
  logic                 serial_tx_q;
  logic                 tx_pronto_q;
  logic                 ocupado_q;
  logic                 fim_q;
  logic                 baud_run;
  logic                 baud_tick;
`ifdef SOBEL_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign baud_run = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clock),
    .rst_i (reset),
    .run_i (baud_run),
    .tick_o(baud_tick)
  );

  // Outputs are registered; ocupado/fim are updated on the transitions that
  // enter or leave IDLE/DONE so they track the state register exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      count_q     <= '0;
      serial_tx_q <= LINE_IDLE;
      tx_pronto_q <= 1'b0;
      ocupado_q   <= 1'b0;
      fim_q       <= 1'b0;
`ifdef SOBEL_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      tx_pronto_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (envia) begin
            state_q   <= ST_LOAD;
            ocupado_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          shreg_q     <= tx_dados;
          bit_idx_q   <= '0;
          serial_tx_q <= START_LEVEL;
          tx_pronto_q <= 1'b1;
          state_q     <= ST_START;
`ifdef SOBEL_TX_PARITY_EN
          parity_q    <= even_parity(tx_dados);
`endif
        end
        ST_START: begin
          if (baud_tick) begin
            serial_tx_q <= shreg_q[0];
            shreg_q     <= {1'b0, shreg_q[DATA_BITS-1:1]};
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef SOBEL_TX_PARITY_EN
              serial_tx_q <= parity_q;
              state_q     <= ST_PARITY;
`else
              serial_tx_q <= STOP_LEVEL;
              state_q     <= ST_STOP;
`endif
            end else begin
              bit_idx_q   <= bit_idx_q + 1'b1;
              serial_tx_q <= shreg_q[0];
              shreg_q     <= {1'b0, shreg_q[DATA_BITS-1:1]};
            end
          end
        end
`ifdef SOBEL_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            serial_tx_q <= STOP_LEVEL;
            state_q     <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            if (count_q == CNT_W'(TOTAL - 1)) begin
              count_q   <= CNT_W'(TOTAL);
              state_q   <= ST_DONE;
              ocupado_q <= 1'b0;
              fim_q     <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
              if (envia) begin
                state_q <= ST_SETTLE;
              end else begin
                state_q   <= ST_IDLE;
                ocupado_q <= 1'b0;
              end
            end
          end
        end
        ST_SETTLE: begin
          state_q <= ST_LOAD;
        end
        ST_DONE: begin
          if (!envia) begin
            state_q <= ST_IDLE;
            fim_q   <= 1'b0;
            count_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          serial_tx_q <= LINE_IDLE;
          ocupado_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_pronto       = tx_pronto_q;
  assign serial_tx       = serial_tx_q;
  assign ocupado         = ocupado_q;
  assign fim_transmissao = fim_q;

endmodule

// File: tb/tb_sobel_uart_tx_streamer.sv
// Scoreboard bench for sobel_uart_tx_streamer: a line monitor decodes frames,
// test tasks push expected bytes and compare decoded frames against them.
module tb_sobel_uart_tx_streamer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned W     = 2;
  localparam int unsigned TOTAL = H * W;
`ifdef SOBEL_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned FRAME_CYC = FB * CPB;
  localparam int          BUDGET    = 4 * (FRAME_CYC + 4) + 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       envia = 1'b0;
  logic       buf_clr = 1'b0;
  logic [7:0] tx_dados;
  logic       tx_pronto, serial_tx, ocupado, fim;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  img [TOTAL];
  int unsigned ptr = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          doubles = 0;
  logic        pronto_prev = 1'b0;

  typedef struct {
    logic [10:0] raw;
    logic        glitch;
    logic        pronto_ok;
    int          start_cyc;
  } rx_t;
  rx_t         rx_log [64];
  int          rx_wr = 0;
  int          rx_rd = 0;
  logic [10:0] mon_raw;
  logic        mon_gl, mon_ab, mon_pok;
  int          mon_sc;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  sobel_uart_tx_streamer #(
    .HEIGHT(H), .WIDTH(W), .CLKS_PER_BIT(CPB)
  ) dut (
    .clock(clk), .reset(rst), .envia(envia), .tx_dados(tx_dados),
    .tx_pronto(tx_pronto), .serial_tx(serial_tx), .ocupado(ocupado),
    .fim_transmissao(fim)
  );

  // Output-buffer model: read pointer advances the cycle after tx_pronto.
  assign tx_dados = img[ptr % TOTAL];
  always @(posedge clk or posedge rst) begin
    if (rst)            ptr <= 0;
    else if (buf_clr)   ptr <= 0;
    else if (tx_pronto) ptr <= ptr + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_pronto === 1'b1) begin
      pulses <= pulses + 1;
      if (pronto_prev === 1'b1) doubles <= doubles + 1;
    end
    pronto_prev <= tx_pronto;
  end

  // Line monitor: every bit must hold for exactly CPB samples.
  always begin
    @(negedge clk);
    if (rst !== 1'b1 && serial_tx === 1'b0) begin
      mon_raw = '1; mon_gl = 1'b0; mon_ab = 1'b0;
      mon_pok = (tx_pronto === 1'b1);
      mon_sc  = cyc;
      for (int b = 0; b < FB && !mon_ab; b++) begin
        for (int c = 0; c < CPB && !mon_ab; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst === 1'b1)               mon_ab = 1'b1;
          else if (c == 0)                mon_raw[b] = serial_tx;
          else if (serial_tx !== mon_raw[b]) mon_gl = 1'b1;
        end
      end
      if (!mon_ab && rx_wr < 64) begin
        rx_log[rx_wr].raw       = mon_raw;
        rx_log[rx_wr].glitch    = mon_gl;
        rx_log[rx_wr].pronto_ok = mon_pok;
        rx_log[rx_wr].start_cyc = mon_sc;
        rx_wr = rx_wr + 1;
      end
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef SOBEL_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (rx_wr >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_img(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    img[0] = a; img[1] = b; img[2] = c; img[3] = d;
    exp_q.delete();
    for (int i = 0; i < int'(TOTAL); i++) exp_q.push_back(img[i]);
    rx_rd = rx_wr;
  endtask

  task automatic test_reset();
    rst = 1'b1; envia = 1'b0;
    tick(); tick();
    vectors++; if (serial_tx !== 1'b1) begin miscompares++; $display("FAIL reset_serial_tx: got %b expected 1", serial_tx); end
    vectors++; if (tx_pronto !== 1'b0) begin miscompares++; $display("FAIL reset_tx_pronto: got %b expected 0", tx_pronto); end
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    vectors++; if (fim !== 1'b0) begin miscompares++; $display("FAIL reset_fim: got %b expected 0", fim); end
    rst = 1'b0;
    tick(); tick();
    vectors++; if (ocupado !== 1'b0 || serial_tx !== 1'b1) begin miscompares++; $display("FAIL idle_after_reset: got ocupado=%b tx=%b expected 0/1", ocupado, serial_tx); end
  endtask

  task automatic test_a5_frame();
    bit ok;
    int pb;
    logic [10:0] seq;
    load_img(8'hA5, 8'h3C, 8'hC3, 8'h5A);
    pb = pulses;
    envia = 1'b1;
    wait_rx(rx_rd + 1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL a5_timeout: got %0d frames expected %0d", rx_wr - rx_rd, 1); end
    if (ok) begin
      vectors++; if (rx_log[rx_rd].raw !== frame_of(exp_q[0])) begin miscompares++; $display("FAIL a5_frame: got %h expected %h", rx_log[rx_rd].raw, frame_of(exp_q[0])); end
      seq = 11'h74A;
`ifndef SOBEL_TX_PARITY_EN
      vectors++; if (rx_log[rx_rd].raw !== seq) begin miscompares++; $display("FAIL a5_bit_sequence: got %b expected %b", rx_log[rx_rd].raw, seq); end
`endif
      vectors++; if (rx_log[rx_rd].glitch !== 1'b0) begin miscompares++; $display("FAIL a5_bit_width: got glitch=%b expected 0", rx_log[rx_rd].glitch); end
      vectors++; if (rx_log[rx_rd].pronto_ok !== 1'b1) begin miscompares++; $display("FAIL a5_pronto_at_start: got %b expected 1", rx_log[rx_rd].pronto_ok); end
    end
    rst = 1'b1; envia = 1'b0;
    #1;
    vectors++; if (pulses - pb != 1) begin miscompares++; $display("FAIL a5_pulse_count: got %0d expected 1", pulses - pb); end
    tick(); rst = 1'b0; tick();
  endtask

  task automatic test_image_2x2();
    bit ok;
    int pb, base;
    logic [7:0] e;
    load_img(8'h00, 8'hFF, 8'hFF, 8'h00);
    pb = pulses; base = rx_rd;
    envia = 1'b1;
    wait_rx(base + 4, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL image_timeout: got %0d frames expected 4", rx_wr - base); end
    vectors++; if (fim !== 1'b0) begin miscompares++; $display("FAIL fim_early: got %b expected 0", fim); end
    tick();
    vectors++; if (fim !== 1'b1 || ocupado !== 1'b0) begin miscompares++; $display("FAIL fim_after_last_stop: got fim=%b ocupado=%b expected 1/0", fim, ocupado); end
    vectors++; if (pulses - pb != 4) begin miscompares++; $display("FAIL image_pulses: got %0d expected 4", pulses - pb); end
    while (rx_rd < rx_wr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (rx_log[rx_rd].raw !== frame_of(e) || rx_log[rx_rd].glitch !== 1'b0) begin miscompares++; $display("FAIL image_frame%0d: got %h glitch=%b expected %h", rx_rd - base, rx_log[rx_rd].raw, rx_log[rx_rd].glitch, frame_of(e)); end
      if (rx_rd > base) begin
        vectors++; if (rx_log[rx_rd].start_cyc - rx_log[rx_rd-1].start_cyc != int'(FRAME_CYC) + 2) begin miscompares++; $display("FAIL back_to_back_gap: got %0d expected %0d", rx_log[rx_rd].start_cyc - rx_log[rx_rd-1].start_cyc, FRAME_CYC + 2); end
      end
      rx_rd++;
    end
  endtask

  task automatic test_done_hold();
    int pb;
    pb = pulses;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++; if (serial_tx !== 1'b1 || fim !== 1'b1) begin miscompares++; $display("FAIL done_hold_cycle%0d: got tx=%b fim=%b expected 1/1", i, serial_tx, fim); end
    end
    vectors++; if (pulses != pb || doubles != 0) begin miscompares++; $display("FAIL done_no_pronto: got %0d pulses %0d doubles expected 0/0", pulses - pb, doubles); end
    envia = 1'b0;
    tick();
    vectors++; if (fim !== 1'b0 || ocupado !== 1'b0 || serial_tx !== 1'b1) begin miscompares++; $display("FAIL done_exit: got fim=%b ocupado=%b tx=%b expected 0/0/1", fim, ocupado, serial_tx); end
    buf_clr = 1'b1; tick(); buf_clr = 1'b0;
  endtask

  task automatic test_pause();
    bit ok;
    int pb, base;
    logic [7:0] e;
    load_img(8'h11, 8'h22, 8'h33, 8'h44);
    pb = pulses; base = rx_rd;
    envia = 1'b1;
    wait_rx(base + 1, ok);
    repeat (12) tick();
    envia = 1'b0;
    wait_rx(base + 2, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pause_frame2_timeout: got %0d frames expected 2", rx_wr - base); end
    repeat (10) tick();
    vectors++; if (ocupado !== 1'b0 || serial_tx !== 1'b1 || fim !== 1'b0) begin miscompares++; $display("FAIL paused_idle: got ocupado=%b tx=%b fim=%b expected 0/1/0", ocupado, serial_tx, fim); end
    vectors++; if (rx_wr - base != 2 || pulses - pb != 2) begin miscompares++; $display("FAIL paused_counts: got %0d frames %0d pulses expected 2/2", rx_wr - base, pulses - pb); end
    envia = 1'b1;
    wait_rx(base + 4, ok);
    tick();
    vectors++; if (!ok || fim !== 1'b1) begin miscompares++; $display("FAIL resume_done: got %0d frames fim=%b expected 4/1", rx_wr - base, fim); end
    while (rx_rd < rx_wr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (rx_log[rx_rd].raw !== frame_of(e)) begin miscompares++; $display("FAIL pause_frame%0d: got %h expected %h", rx_rd - base, rx_log[rx_rd].raw, frame_of(e)); end
      rx_rd++;
    end
    envia = 1'b0;
    tick(); tick();
    buf_clr = 1'b1; tick(); buf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int base;
    logic [7:0] e;
    load_img(8'h5A, 8'hA5, 8'h0F, 8'hF0);
    base = rx_rd;
    envia = 1'b1;
    wait_rx(base + 1, ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (serial_tx === 1'b0) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL frame2_start_timeout: got tx=%b expected 0", serial_tx); end
    repeat (17) tick();
    rst = 1'b1;
    #1;
    vectors++; if (serial_tx !== 1'b1 || ocupado !== 1'b0 || tx_pronto !== 1'b0 || fim !== 1'b0) begin miscompares++; $display("FAIL reset_mid_frame: got tx=%b ocupado=%b pronto=%b fim=%b expected 1/0/0/0", serial_tx, ocupado, tx_pronto, fim); end
    envia = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    load_img(8'h5A, 8'hA5, 8'h0F, 8'hF0);
    base = rx_rd;
    envia = 1'b1;
    wait_rx(base + 4, ok);
    tick();
    vectors++; if (!ok || fim !== 1'b1) begin miscompares++; $display("FAIL restart_full_image: got %0d frames fim=%b expected 4/1", rx_wr - base, fim); end
    while (rx_rd < rx_wr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (rx_log[rx_rd].raw !== frame_of(e)) begin miscompares++; $display("FAIL restart_frame%0d: got %h expected %h", rx_rd - base, rx_log[rx_rd].raw, frame_of(e)); end
      rx_rd++;
    end
    envia = 1'b0;
    tick(); tick();
    buf_clr = 1'b1; tick(); buf_clr = 1'b0;
  endtask

  task automatic test_parity_07();
    bit ok;
    int base;
    load_img(8'h07, 8'h07, 8'h07, 8'h07);
    base = rx_rd;
    envia = 1'b1;
    wait_rx(base + 2, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL parity_timeout: got %0d frames expected 2", rx_wr - base); end
    if (ok) begin
      vectors++; if (rx_log[base].raw !== frame_of(8'h07) || rx_log[base].raw[9] !== 1'b1) begin miscompares++; $display("FAIL byte07_frame: got %b expected %b", rx_log[base].raw, frame_of(8'h07)); end
      vectors++; if (rx_log[base+1].start_cyc - rx_log[base].start_cyc != int'(FRAME_CYC) + 2) begin miscompares++; $display("FAIL byte07_frame_len: got %0d expected %0d", rx_log[base+1].start_cyc - rx_log[base].start_cyc, FRAME_CYC + 2); end
    end
    rst = 1'b1; envia = 1'b0;
    tick(); rst = 1'b0; tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_a5_frame();
    test_image_2x2();
    test_done_hold();
    test_pause();
    test_reset_mid();
    test_parity_07();
    vectors++; if (doubles != 0) begin miscompares++; $display("FAIL pronto_width: got %0d multi-cycle pulses expected 0", doubles); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
